gpu_reg_bank_server: RTL and testbench
======================================

Name: gpu_reg_bank_server

Overview:
Responder side of the warp operand-request interface. Accepts a two-operand register read request tagged with a warp number and serves it from NUM_BANKS single-read-port register banks. Bank conflicts are serialized and writebacks have priority over reads. Returns both operands with the warp tag over a valid/ready response channel. Sits between the warp issue stage and the thread execute units.

Parameters:
NUM_BANKS, 4, number of register banks; power of two; bank index = low BANK_W address bits
REGS_PER_BANK, 64, rows per bank; power of two
DATA_W, 64, operand width in bits
WARP_W, 5, warp number width
(derived) BANK_W = clog2(NUM_BANKS); ADDR_W = clog2(NUM_BANKS*REGS_PER_BANK)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  operand request valid
req_ready  out  1  request accepted when both valid and ready are high
req_warp  in  WARP_W  requesting warp number
req_addr1  in  ADDR_W  operand 1 register address
req_addr2  in  ADDR_W  operand 2 register address
req_use2  in  1  operand 2 present; 0 means immediate/unused
wb_valid  in  1  writeback strobe; always accepted
wb_addr  in  ADDR_W  writeback register address
wb_data  in  DATA_W  writeback data
resp_valid  out  1  response valid
resp_ready  in  1  consumer ready
resp_warp  out  WARP_W  echoed warp number
resp_data1  out  DATA_W  operand 1 value
resp_data2  out  DATA_W  operand 2 value; 0 when req_use2=0
resp_conflict  out  1  1 if the request was serialized by a bank conflict

Behaviour:
- Address split: bank = addr[BANK_W-1:0]; row = addr[ADDR_W-1:BANK_W].
- Each bank has 1 write port and 1 read port. Read is combinational from flop storage and captured into response registers at the clock edge.
- State machine IDLE -> RD1 -> (RD2) -> HOLD -> IDLE.
- req_ready = (state==IDLE). On accept, latch warp, addr1, addr2, use2. Go to RD1.
- RD1:
  - Conflict exists when use2=1, bank(addr1)==bank(addr2) and addr1!=addr2.
  - No conflict: capture op1 (and op2 if use2) and go to HOLD.
  - addr1==addr2: one read feeds both data outputs; not a conflict.
  - Conflict: capture op1, set conflict flag, go to RD2. RD2 captures op2, then goes to HOLD.
- Writeback priority:
  - A wb_valid write to bank b occupies b's read port that cycle.
  - Any read in RD1/RD2 targeting bank b stalls in the same state for that cycle; the other operand's read also waits, so RD1 captures both together.
  - Stalls repeat while writebacks keep hitting the bank.
  - A write becomes readable the next cycle. A stalled read of the same address returns the new data.
- Latency from accept edge T:
  - resp_valid at T+2 with no conflict or stall.
  - T+3 with a conflict.
  - Plus 1 cycle per writeback stall.
- HOLD: resp_valid=1. resp_warp, resp_data1, resp_data2 and resp_conflict are held stable until resp_valid&&resp_ready; then go to IDLE next cycle. resp_valid may drop combinationally-registered with state.
- Throughput: at most one request per 3 cycles. No request is accepted outside IDLE.
- Writebacks are accepted in every state, including IDLE and HOLD. A writeback in HOLD does not alter already captured data.
- Reset (async assert, sync deassert assumed upstream):
  - State goes to IDLE. resp_valid=0; resp_warp, resp_data*, resp_conflict=0.
  - All bank contents are cleared to 0. req_ready=1 once reset is released.
  - A reset mid-request discards the request; no response is produced.
- Writeback address out of range cannot occur, because ADDR_W exactly covers the storage.

Decomposition:
- Package gpu_bank_pkg holds NUM_BANKS/REGS_PER_BANK/DATA_W/WARP_W defaults, BANK_W/ADDR_W derivation, the state enum (IDLE, RD1, RD2, HOLD), and bank/row extraction functions.
- Sub-module gpu_reg_bank: one bank with 1 synchronous write port, 1 combinational read port and async-reset clear. Instantiated NUM_BANKS times via generate.

Test Plan:
All scenarios use the default parameters (NUM_BANKS=4).
- Preload and no conflict: wb 0x05=0xAAAA and 0x0A=0xBBBB; then request warp 3, addr1=0x05, addr2=0x0A, use2=1, accepted at T -> resp_valid at T+2, data1=0xAAAA, data2=0xBBBB, resp_warp=3, conflict=0.
- Bank conflict: wb 0x09=0xCCCC; request addr1=0x05, addr2=0x09 (both bank 1) -> resp_valid at T+3, data1=0xAAAA, data2=0xCCCC, conflict=1.
- Writeback stall and ordering: request addr1=0x05, addr2=0x0A with wb 0x05=0x1234 in cycle T+1 -> resp_valid at T+3, data1=0x1234, data2=0xBBBB, conflict=0.
- Same address / single operand:
  - addr1=addr2=0x0A -> T+2, both data=0xBBBB, conflict=0.
  - use2=0 -> data2=0.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> outputs stable, req_ready=0 throughout. Raise resp_ready -> handshake; req_ready=1 the next cycle.
- Reset mid-operation: pull rst_n low at T+1 of a pending request -> resp_valid=0 immediately. After release: req_ready=1, no response emitted, and a read of 0x05 returns 0.

Source files
------------

// File: rtl/gpu_reg_bank_server_pkg.sv
// Shared defaults, FSM state type and address split helpers for the operand
// register bank server.
package gpu_bank_pkg;

    localparam int NUM_BANKS_DEF     = 4;
    localparam int REGS_PER_BANK_DEF = 64;
    localparam int DATA_W_DEF        = 64;
    localparam int WARP_W_DEF        = 5;
    localparam int BANK_W_DEF        = $clog2(NUM_BANKS_DEF);
    localparam int ADDR_W_DEF        = $clog2(NUM_BANKS_DEF * REGS_PER_BANK_DEF);

    typedef enum logic [1:0] {IDLE, RD1, RD2, HOLD} state_t;

    // Bank is the low bank_w address bits, row is everything above them.
    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned bank_w);
        return addr & ((32'd1 << bank_w) - 32'd1);
    endfunction

    function automatic int unsigned row_of(input int unsigned addr, input int unsigned bank_w);
        return addr >> bank_w;
    endfunction

endpackage

// File: rtl/gpu_reg_bank_server_if.sv
// Operand request, writeback and response channels between the warp issue
// stage (master) and the register bank server (slave).
interface gpu_reg_bank_server_if
    import gpu_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WARP_W = WARP_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [WARP_W-1:0] req_warp;
    logic [ADDR_W-1:0] req_addr1;
    logic [ADDR_W-1:0] req_addr2;
    logic              req_use2;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              resp_valid;
    logic              resp_ready;
    logic [WARP_W-1:0] resp_warp;
    logic [DATA_W-1:0] resp_data1;
    logic [DATA_W-1:0] resp_data2;
    logic              resp_conflict;

    modport master (
        output req_valid, req_warp, req_addr1, req_addr2, req_use2,
        output wb_valid, wb_addr, wb_data,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_warp, resp_data1, resp_data2, resp_conflict
    );

    modport slave (
        input  req_valid, req_warp, req_addr1, req_addr2, req_use2,
        input  wb_valid, wb_addr, wb_data,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_warp, resp_data1, resp_data2, resp_conflict
    );

endinterface

// File: rtl/gpu_reg_bank.sv
// One register bank: flop storage, one synchronous write port, one
// combinational read port, cleared to zero on reset.
module gpu_reg_bank #(
    parameter int REGS   = 64,
    parameter int DATA_W = 64,
    parameter int ROW_W  = $clog2(REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ROW_W-1:0]  wrow,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ROW_W-1:0]  rrow,
    output logic [DATA_W-1:0] rdata
);

    logic [REGS-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[wrow] <= wdata;
        end
    end

    assign rdata = mem[rrow];

endmodule

// File: rtl/gpu_reg_bank_server.sv
// Serves two-operand register reads from banked storage; bank conflicts are
// split over two read cycles and writebacks steal the read port of their bank.
module gpu_reg_bank_server
    import gpu_bank_pkg::*;
#(
    parameter int NUM_BANKS     = NUM_BANKS_DEF,
    parameter int REGS_PER_BANK = REGS_PER_BANK_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int WARP_W        = WARP_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gpu_reg_bank_server_if.slave  bus
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = $clog2(REGS_PER_BANK);
    localparam int ADDR_W = BANK_W + ROW_W;

    state_t              state;
    logic [WARP_W-1:0]   warp_q;
    logic [ADDR_W-1:0]   addr1_q;
    logic [ADDR_W-1:0]   addr2_q;
    logic                use2_q;

    logic                ready_q;
    logic                valid_q;
    logic [WARP_W-1:0]   warp_o;
    logic [DATA_W-1:0]   data1_o;
    logic [DATA_W-1:0]   data2_o;
    logic                conflict_o;

    logic [BANK_W-1:0]   bank1, bank2, wb_bank;
    logic [ROW_W-1:0]    row1, row2, wb_row;
    logic                conflict;
    logic                stall;
    logic [NUM_BANKS-1:0][ROW_W-1:0]  rd_row;
    logic [NUM_BANKS-1:0][DATA_W-1:0] rd_data;
    logic [DATA_W-1:0]   op1, op2;

    assign bank1   = BANK_W'(bank_of(32'(addr1_q), BANK_W));
    assign bank2   = BANK_W'(bank_of(32'(addr2_q), BANK_W));
    assign wb_bank = BANK_W'(bank_of(32'(bus.wb_addr), BANK_W));
    assign row1    = ROW_W'(row_of(32'(addr1_q), BANK_W));
    assign row2    = ROW_W'(row_of(32'(addr2_q), BANK_W));
    assign wb_row  = ROW_W'(row_of(32'(bus.wb_addr), BANK_W));

    // Identical addresses share one read, so only distinct rows in one bank conflict.
    assign conflict = use2_q && (bank1 == bank2) && (addr1_q != addr2_q);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign rd_row[b] = (state == RD2 ||
                            (use2_q && !conflict && bank2 == BANK_W'(b) && bank1 != BANK_W'(b)))
                           ? row2 : row1;

        gpu_reg_bank #(
            .REGS   (REGS_PER_BANK),
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bus.wb_valid && wb_bank == BANK_W'(b)),
            .wrow  (wb_row),
            .wdata (bus.wb_data),
            .rrow  (rd_row[b]),
            .rdata (rd_data[b])
        );
    end

    assign op1 = rd_data[bank1];
    assign op2 = rd_data[bank2];

    // A writeback to any bank this cycle's reads need holds the whole read step.
    always_comb begin
        stall = 1'b0;
        case (state)
            RD1:     stall = bus.wb_valid &&
                             (wb_bank == bank1 || (use2_q && !conflict && wb_bank == bank2));
            RD2:     stall = bus.wb_valid && wb_bank == bank2;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            warp_q     <= '0;
            addr1_q    <= '0;
            addr2_q    <= '0;
            use2_q     <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            warp_o     <= '0;
            data1_o    <= '0;
            data2_o    <= '0;
            conflict_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    warp_q  <= bus.req_warp;
                    addr1_q <= bus.req_addr1;
                    addr2_q <= bus.req_addr2;
                    use2_q  <= bus.req_use2;
                    ready_q <= 1'b0;
                    state   <= RD1;
                end
                RD1: if (!stall) begin
                    warp_o  <= warp_q;
                    data1_o <= op1;
                    if (conflict) begin
                        conflict_o <= 1'b1;
                        state      <= RD2;
                    end else begin
                        data2_o    <= use2_q ? op2 : '0;
                        conflict_o <= 1'b0;
                        valid_q    <= 1'b1;
                        state      <= HOLD;
                    end
                end
                RD2: if (!stall) begin
                    data2_o <= op2;
                    valid_q <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: if (bus.resp_ready) begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.resp_valid    = valid_q;
    assign bus.resp_warp     = warp_o;
    assign bus.resp_data1    = data1_o;
    assign bus.resp_data2    = data2_o;
    assign bus.resp_conflict = conflict_o;

endmodule

// File: tb/tb_gpu_reg_bank_server.sv
// Bench for gpu_reg_bank_server: directed literal scenarios plus randomized
// traffic compared every cycle against a phase-level reference model.
module tb_gpu_reg_bank_server;
    import gpu_bank_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    gpu_reg_bank_server_if bus ();

    gpu_reg_bank_server dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a request is a list of read phases; a phase finishes in
    // the first cycle no writeback lands on a bank it needs.
    logic [63:0] mmem [256];
    logic        m_ready = 1'b1, m_valid = 1'b0;
    logic [4:0]  m_warp_o = '0;
    logic [63:0] m_d1 = '0, m_d2 = '0;
    logic        m_conf = 1'b0;
    int          m_phase = 0;
    logic [4:0]  r_warp;
    logic [7:0]  r_a1, r_a2;
    logic        r_use2, r_split;
    logic        acc, rel, blocked;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mmem[i] = '0;
            m_ready = 1'b1; m_valid = 1'b0; m_phase = 0;
            m_warp_o = '0; m_d1 = '0; m_d2 = '0; m_conf = 1'b0;
        end else begin
            acc = m_ready && bus.req_valid;
            rel = m_valid && bus.resp_ready;
            if (m_phase == 1) begin
                blocked = bus.wb_valid && (bus.wb_addr[1:0] == r_a1[1:0] ||
                          (r_use2 && !r_split && bus.wb_addr[1:0] == r_a2[1:0]));
                if (!blocked) begin
                    m_d1 = mmem[r_a1];
                    m_warp_o = r_warp;
                    m_conf = r_split;
                    if (r_split) m_phase = 2;
                    else begin
                        m_d2 = r_use2 ? mmem[r_a2] : 64'd0;
                        m_phase = 0; m_valid = 1'b1;
                    end
                end
            end else if (m_phase == 2) begin
                if (!(bus.wb_valid && bus.wb_addr[1:0] == r_a2[1:0])) begin
                    m_d2 = mmem[r_a2];
                    m_phase = 0; m_valid = 1'b1;
                end
            end
            if (rel) begin m_valid = 1'b0; m_ready = 1'b1; end
            if (acc) begin
                r_warp = bus.req_warp; r_a1 = bus.req_addr1; r_a2 = bus.req_addr2;
                r_use2 = bus.req_use2;
                r_split = bus.req_use2 && bus.req_addr1[1:0] == bus.req_addr2[1:0] &&
                          bus.req_addr1 != bus.req_addr2;
                m_phase = 1; m_ready = 1'b0;
            end
            if (bus.wb_valid) mmem[bus.wb_addr] = bus.wb_data;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 64'(bus.req_ready), 64'(m_ready));
        chk("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
        if (m_valid) begin
            chk("resp_warp", 64'(bus.resp_warp), 64'(m_warp_o));
            chk("resp_data1", bus.resp_data1, m_d1);
            chk("resp_data2", bus.resp_data2, m_d2);
            chk("resp_conflict", 64'(bus.resp_conflict), 64'(m_conf));
        end
    end

    task automatic wb(input logic [7:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        bus.wb_valid = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
    endtask

    // Returns in cycle T+1 (just after the accepting edge) with t = T.
    task automatic send(input logic [4:0] w, input logic [7:0] a1, input logic [7:0] a2,
                        input logic u2, output int t);
        t = -1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_warp = w;
        bus.req_addr1 = a1; bus.req_addr2 = a2; bus.req_use2 = u2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin t = cyc; break; end
        end
        if (t < 0) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int t, output int lat);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.resp_valid) begin lat = cyc - t; break; end
            @(negedge clk);
        end
        if (lat < 0) chk("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic expect_resp(input string tag, input int lat, input int exp_lat,
                               input logic [4:0] w, input logic [63:0] d1,
                               input logic [63:0] d2, input logic c);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_warp"}, 64'(bus.resp_warp), 64'(w));
        chk({tag, "_data1"}, bus.resp_data1, d1);
        chk({tag, "_data2"}, bus.resp_data2, d2);
        chk({tag, "_conflict"}, 64'(bus.resp_conflict), 64'(c));
    endtask

    initial begin
        int t, lat;
        logic [63:0] h1, h2;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_warp = '0; bus.req_addr1 = '0; bus.req_addr2 = '0;
        bus.req_use2 = 1'b0; bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data1", bus.resp_data1, 64'd0);
        chk("rst_resp_conflict", 64'(bus.resp_conflict), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

        wb(8'h05, 64'hAAAA);
        wb(8'h0A, 64'hBBBB);
        send(5'd3, 8'h05, 8'h0A, 1'b1, t);
        wait_resp(t, lat);
        expect_resp("noconf", lat, 2, 5'd3, 64'hAAAA, 64'hBBBB, 1'b0);

        wb(8'h09, 64'hCCCC);
        send(5'd7, 8'h05, 8'h09, 1'b1, t);
        wait_resp(t, lat);
        expect_resp("conf", lat, 3, 5'd7, 64'hAAAA, 64'hCCCC, 1'b1);

        send(5'd1, 8'h05, 8'h0A, 1'b1, t);
        bus.wb_valid = 1'b1; bus.wb_addr = 8'h05; bus.wb_data = 64'h1234;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        wait_resp(t, lat);
        expect_resp("stall", lat, 3, 5'd1, 64'h1234, 64'hBBBB, 1'b0);

        send(5'd2, 8'h0A, 8'h0A, 1'b1, t);
        wait_resp(t, lat);
        expect_resp("same", lat, 2, 5'd2, 64'hBBBB, 64'hBBBB, 1'b0);

        send(5'd4, 8'h0A, 8'h05, 1'b0, t);
        wait_resp(t, lat);
        expect_resp("use2_0", lat, 2, 5'd4, 64'hBBBB, 64'd0, 1'b0);

        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        send(5'd9, 8'h09, 8'h0A, 1'b1, t);
        wait_resp(t, lat);
        expect_resp("bp", lat, 2, 5'd9, 64'hCCCC, 64'hBBBB, 1'b0);
        h1 = bus.resp_data1; h2 = bus.resp_data2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.resp_valid), 64'd1);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_data1_stable", bus.resp_data1, h1);
            chk("bp_data2_stable", bus.resp_data2, h2);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", 64'(bus.req_ready), 64'd1);
        chk("bp_release_valid", 64'(bus.resp_valid), 64'd0);

        send(5'd5, 8'h05, 8'h0A, 1'b1, t);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.resp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", 64'(bus.resp_valid), 64'd0);
            chk("midrst_ready", 64'(bus.req_ready), 64'd1);
        end
        send(5'd6, 8'h05, 8'h00, 1'b0, t);
        wait_resp(t, lat);
        expect_resp("cleared", lat, 2, 5'd6, 64'd0, 64'd0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            bus.wb_valid   = ($urandom_range(0, 2) == 0);
            bus.wb_addr    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            bus.wb_data    = {$urandom, $urandom};
            bus.req_valid  = ($urandom_range(0, 1) == 0);
            bus.req_warp   = 5'($urandom);
            bus.req_addr1  = 8'($urandom_range(0, 15));
            bus.req_addr2  = ($urandom_range(0, 3) == 0) ? bus.req_addr1 : 8'($urandom_range(0, 15));
            bus.req_use2   = ($urandom_range(0, 4) != 0);
            bus.resp_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.wb_valid = 1'b0; bus.resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
